mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory (M) stage, directly downstream of the E/M pipeline register.
//  - Non-memory ops: passes aluResult to writeback in 1 cycle.
//  - Loads/stores: runs a req/resp handshake with the data memory and steers byte/half lanes.
//  - Drives the stall back into E/M while an access is in flight.
//  - Produces a registered writeback record tagged with rob_id.
// PARAMETERS
//  WORD_SIZE  32  datapath/address width
//  ROB_ID_W   7   reorder-buffer tag width
// PORTS
//  clk             in   1          rising-edge clock
//  reset           in   1          reset, synchronous, active-high
//  in_valid        in   1          E/M record valid
//  in_itype        in   2          instruction_type (ITYPE_* from package)
//  in_pc           in   WORD_SIZE  instruction PC
//  in_funct3       in   3          access size/sign
//  in_alu_result   in   WORD_SIZE  ALU result / effective address
//  in_s2           in   WORD_SIZE  store data
//  in_rob_id       in   ROB_ID_W   ROB tag
//  stall_out       out  1          hold E/M register
//  mem_req_valid   out  1          memory request valid
//  mem_req_ready   in   1          memory accepts request
//  mem_we          out  1          1=store
//  mem_addr        out  WORD_SIZE  word-aligned address ({addr[W-1:2],2'b00})
//  mem_wdata       out  WORD_SIZE  lane-replicated store data
//  mem_wstrb       out  4          byte enables
//  mem_resp_valid  in   1          read data / store ack valid
//  mem_rdata       in   WORD_SIZE  read word
//  wb_valid        out  1          writeback record valid (1-cycle pulse per op)
//  wb_result       out  WORD_SIZE  load data / ALU result
//  wb_pc           out  WORD_SIZE  PC of completing op
//  wb_rob_id       out  ROB_ID_W   ROB tag
//  wb_exception    out  1          misaligned access (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE; wb_valid=0, wb_exception=0, mem_req_valid=0; wb_result/pc/rob_id=0.
//  - FSM IDLE/REQ/WAIT:
//    - IDLE + in_valid + itype in {LOAD,STORE}: latch the whole record into op regs; ->REQ.
//    - REQ: mem_req_valid=1 (from op regs); ->WAIT on mem_req_ready.
//    - WAIT: on mem_resp_valid, register wb_* (wb_valid=1 next cycle); ->IDLE.
//    - mem_resp_valid outside WAIT is ignored.
//  - Non-memory op (ALU/OTHER) in IDLE: wb_valid=1 the following cycle, wb_result=in_alu_result, no stall.
//  - stall_out = (IDLE & in_valid & mem op) | REQ | (WAIT & !mem_resp_valid). Combinational.
//    - On the response cycle stall_out=0, so E/M advances while wb_* is written.
//  - Loads, offset o=addr[1:0]:
//    - LB/LBU(000/100): byte o, sign-/zero-extended.
//    - LH/LHU(001/101): half at o[1], sign-/zero-extended.
//    - LW(010): full word.
//    - Stores write wb_result=0.
//  - Stores, write data and strobes:
//    - SB: wdata={4{s2[7:0]}}, wstrb=1<<o.
//    - SH: wdata={2{s2[15:0]}}, wstrb=3<<{o[1],1'b0}.
//    - SW: wdata=s2, wstrb=4'hF.
//  - Undefined funct3 on a mem op: treated as LW/SW.
//  - Best case (ready and resp both immediate) is 3 cycles per mem op; no bubble after an ALU op.
//  - Reset mid-access: FSM->IDLE immediately, request dropped, the late response is ignored.
// CONFIGURATION
//  - Macro MEM_MISALIGN_TRAP_EN.
//  - Defined: a half with o[0]=1 or a word with o!=0 issues no request.
//    - Next cycle: wb_valid=1, wb_exception=1, wb_result=effective address. No stall.
//  - Undefined: misaligned low bits are masked to the access size and the access proceeds.
//    - wb_exception is tied to 0.
// STRUCTURE
//  - Package mem_stage_pkg: ITYPE_ALU=0, ITYPE_LOAD=1, ITYPE_STORE=2, ITYPE_OTHER=3;
//    F3_B/H/W/BU/HU constants; state enum.
//  - Sub-module load_store_align (combinational): wdata/wstrb generation and rdata
//    extraction/sign-extension; also misalignment detect.
// TESTING
//  - ALU op, alu=0x1234, rob 5 -> next cycle wb_valid=1, wb_result=0x1234, stall_out never high.
//  - LB addr 0x103, rdata 0x80FF_FF00, ready/resp immediate
//    -> wb_result=0xFFFFFF80, mem_addr=0x100, wb_valid 3 cycles after accept.
//  - SH addr 0x102, s2=0xABCD -> wstrb=4'b1100, wdata=0xABCDABCD, mem_we=1, wb_result=0.
//  - LW with ready delayed 2 and resp delayed 3 -> stall_out high every cycle until the resp cycle;
//    wb_* exactly once; the next E/M op then accepted.
//  - Reset asserted in WAIT, resp arrives the cycle after -> no wb_valid; FSM IDLE; next op OK.
//  - With MEM_MISALIGN_TRAP_EN, LW addr 0x102 -> no mem_req_valid;
//    wb_exception=1, wb_result=0x102.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types for the M stage: instruction classes, funct3 access codes, FSM states.
package mem_stage_pkg;

    localparam logic [1:0] ITYPE_ALU   = 2'd0;
    localparam logic [1:0] ITYPE_LOAD  = 2'd1;
    localparam logic [1:0] ITYPE_STORE = 2'd2;
    localparam logic [1:0] ITYPE_OTHER = 2'd3;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    function automatic logic is_mem_itype(input logic [1:0] itype);
        return (itype == ITYPE_LOAD) || (itype == ITYPE_STORE);
    endfunction

    // Stores have no unsigned forms, so BU/HU codes on a store fall back to a word access.
    function automatic size_e decode_size(input logic is_store, input logic [2:0] funct3);
        size_e sz;
        case (funct3)
            F3_B:    sz = SZ_B;
            F3_H:    sz = SZ_H;
            F3_BU:   sz = is_store ? SZ_W : SZ_B;
            F3_HU:   sz = is_store ? SZ_W : SZ_H;
            default: sz = SZ_W;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Combinational lane steering: store data replication/strobes, load extraction and
// sign-extension, and misalignment detection for the given access.
module load_store_align
    import mem_stage_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic                 is_store,
    input  logic [2:0]           funct3,
    input  logic [1:0]           offset,
    input  logic [WORD_SIZE-1:0] s2,
    input  logic [WORD_SIZE-1:0] rdata,
    output logic [WORD_SIZE-1:0] wdata,
    output logic [3:0]           wstrb,
    output logic [WORD_SIZE-1:0] load_data,
    output logic                 misaligned
);

    size_e      size;
    logic [1:0] eff_off;
    logic [7:0] ld_byte;
    logic [15:0] ld_half;
    logic       sext;

    assign size = decode_size(is_store, funct3);
    assign sext = ~funct3[2];

    // Low offset bits below the access size are dropped; a trapping build never gets here with them set.
    always_comb begin
        misaligned = 1'b0;
        eff_off    = offset;
        case (size)
            SZ_H: begin
                misaligned = offset[0];
                eff_off    = {offset[1], 1'b0};
            end
            SZ_W: begin
                misaligned = (offset != 2'b00);
                eff_off    = 2'b00;
            end
            default: ;
        endcase
    end

    assign ld_byte = rdata[{eff_off, 3'b000} +: 8];
    assign ld_half = rdata[{eff_off[1], 4'b0000} +: 16];

    always_comb begin
        wdata     = s2;
        wstrb     = 4'hF;
        load_data = rdata;
        case (size)
            SZ_B: begin
                wdata     = {(WORD_SIZE/8){s2[7:0]}};
                wstrb     = 4'b0001 << eff_off;
                load_data = {{(WORD_SIZE-8){sext & ld_byte[7]}}, ld_byte};
            end
            SZ_H: begin
                wdata     = {(WORD_SIZE/16){s2[15:0]}};
                wstrb     = 4'b0011 << eff_off;
                load_data = {{(WORD_SIZE-16){sext & ld_half[15]}}, ld_half};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: single-cycle ALU pass-through, IDLE/REQ/WAIT memory handshake, registered writeback.
// Optional MEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into an exception writeback.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int ROB_ID_W  = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [1:0]           in_itype,
    input  logic [WORD_SIZE-1:0] in_pc,
    input  logic [2:0]           in_funct3,
    input  logic [WORD_SIZE-1:0] in_alu_result,
    input  logic [WORD_SIZE-1:0] in_s2,
    input  logic [ROB_ID_W-1:0]  in_rob_id,
    output logic                 stall_out,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    output logic [3:0]           mem_wstrb,
    input  logic                 mem_resp_valid,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 wb_valid,
    output logic [WORD_SIZE-1:0] wb_result,
    output logic [WORD_SIZE-1:0] wb_pc,
    output logic [ROB_ID_W-1:0]  wb_rob_id,
    output logic                 wb_exception
);

`ifdef MEM_MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    state_e state_q, state_d;

    logic [1:0]           op_itype_q;
    logic [2:0]           op_funct3_q;
    logic [WORD_SIZE-1:0] op_pc_q, op_addr_q, op_s2_q;
    logic [ROB_ID_W-1:0]  op_rob_q;

    logic                 wb_valid_q;
    logic [WORD_SIZE-1:0] wb_result_q, wb_pc_q;
    logic [ROB_ID_W-1:0]  wb_rob_q;

    logic                 al_is_store, al_misaligned;
    logic [2:0]           al_funct3;
    logic [1:0]           al_offset;
    logic [WORD_SIZE-1:0] al_s2, al_wdata, al_load;
    logic [3:0]           al_wstrb;

    logic in_mem, in_trap, in_issue, sel_in;
    logic op_load, wb_alu, wb_trap, wb_mem;

    // In IDLE the aligner looks at the incoming record (misalign check); otherwise at the held op.
    assign sel_in      = (state_q == ST_IDLE);
    assign al_is_store = sel_in ? (in_itype == ITYPE_STORE) : (op_itype_q == ITYPE_STORE);
    assign al_funct3   = sel_in ? in_funct3 : op_funct3_q;
    assign al_offset   = sel_in ? in_alu_result[1:0] : op_addr_q[1:0];
    assign al_s2       = sel_in ? in_s2 : op_s2_q;

    load_store_align #(.WORD_SIZE(WORD_SIZE)) u_align (
        .is_store   (al_is_store),
        .funct3     (al_funct3),
        .offset     (al_offset),
        .s2         (al_s2),
        .rdata      (mem_rdata),
        .wdata      (al_wdata),
        .wstrb      (al_wstrb),
        .load_data  (al_load),
        .misaligned (al_misaligned)
    );

    assign in_mem   = in_valid & is_mem_itype(in_itype);
    assign in_trap  = TRAP_EN & in_mem & al_misaligned;
    assign in_issue = in_mem & ~in_trap;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_issue)       state_d = ST_REQ;
            ST_REQ:  if (mem_req_ready)  state_d = ST_WAIT;
            ST_WAIT: if (mem_resp_valid) state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req_valid = 1'b0;
        stall_out     = 1'b0;
        op_load       = 1'b0;
        wb_alu        = 1'b0;
        wb_trap       = 1'b0;
        wb_mem        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall_out = in_issue;
                op_load   = in_issue;
                wb_alu    = in_valid & ~is_mem_itype(in_itype);
                wb_trap   = in_trap;
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                stall_out     = 1'b1;
            end
            ST_WAIT: begin
                stall_out = ~mem_resp_valid;
                wb_mem    = mem_resp_valid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_itype_q  <= ITYPE_ALU;
            op_funct3_q <= '0;
            op_pc_q     <= '0;
            op_addr_q   <= '0;
            op_s2_q     <= '0;
            op_rob_q    <= '0;
        end else if (op_load) begin
            op_itype_q  <= in_itype;
            op_funct3_q <= in_funct3;
            op_pc_q     <= in_pc;
            op_addr_q   <= in_alu_result;
            op_s2_q     <= in_s2;
            op_rob_q    <= in_rob_id;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_q  <= 1'b0;
            wb_result_q <= '0;
            wb_pc_q     <= '0;
            wb_rob_q    <= '0;
        end else begin
            wb_valid_q <= wb_alu | wb_trap | wb_mem;
            if (wb_alu | wb_trap) begin
                wb_result_q <= in_alu_result;
                wb_pc_q     <= in_pc;
                wb_rob_q    <= in_rob_id;
            end else if (wb_mem) begin
                wb_result_q <= (op_itype_q == ITYPE_STORE) ? '0 : al_load;
                wb_pc_q     <= op_pc_q;
                wb_rob_q    <= op_rob_q;
            end
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic wb_exc_q;
    always_ff @(posedge clk) begin
        if (reset) wb_exc_q <= 1'b0;
        else       wb_exc_q <= wb_trap;
    end
    assign wb_exception = wb_exc_q;
`else
    assign wb_exception = 1'b0;
`endif

    assign mem_we    = (op_itype_q == ITYPE_STORE);
    assign mem_addr  = {op_addr_q[WORD_SIZE-1:2], 2'b00};
    assign mem_wdata = al_wdata;
    assign mem_wstrb = al_wstrb;

    assign wb_valid  = wb_valid_q;
    assign wb_result = wb_result_q;
    assign wb_pc     = wb_pc_q;
    assign wb_rob_id = wb_rob_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against an arithmetic reference of the access rules.
module tb_mem_stage;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [1:0]  in_itype = '0;
    logic [31:0] in_pc = '0, in_alu_result = '0, in_s2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_rob_id = '0;
    logic        stall_out, mem_req_valid, mem_we;
    logic        mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [3:0]  mem_wstrb;
    logic        wb_valid, wb_exception;
    logic [31:0] wb_result, wb_pc;
    logic [6:0]  wb_rob_id;

    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    mem_stage #(.WORD_SIZE(32), .ROB_ID_W(7)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_itype(in_itype), .in_pc(in_pc),
        .in_funct3(in_funct3), .in_alu_result(in_alu_result), .in_s2(in_s2), .in_rob_id(in_rob_id),
        .stall_out(stall_out), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
        .wb_result(wb_result), .wb_pc(wb_pc), .wb_rob_id(wb_rob_id), .wb_exception(wb_exception)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---- reference model: access size in bytes, then plain arithmetic on offsets ----
    function automatic int ref_size(input bit st, input logic [2:0] f3);
        if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    endfunction

    function automatic bit ref_misal(input bit st, input logic [2:0] f3, input logic [31:0] a);
        int sz = ref_size(st, f3);
        int o  = int'(a % 4);
        return (sz == 2 && (o % 2) == 1) || (sz == 4 && o != 0);
    endfunction

    function automatic int ref_off(input bit st, input logic [2:0] f3, input logic [31:0] a);
        int sz = ref_size(st, f3);
        int o  = int'(a % 4);
        return o - (o % sz);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        int sz = ref_size(1'b0, f3);
        int o  = ref_off(1'b0, f3, a);
        longint unsigned v = 64'(rd);
        v = (v >> (8 * o)) % (64'd1 << (8 * sz));
        if (sz < 4 && f3 < 3'd4 && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] s2);
        int sz = ref_size(1'b1, f3);
        if (sz == 1) return (s2 % 256) * 32'h0101_0101;
        if (sz == 2) return (s2 % 65536) * 32'h0001_0001;
        return s2;
    endfunction

    function automatic logic [31:0] ref_wstrb(input logic [2:0] f3, input logic [31:0] a);
        int sz = ref_size(1'b1, f3);
        int o  = ref_off(1'b1, f3, a);
        return ((32'd1 << sz) - 1) << o;
    endfunction

    // Presents one E/M record (held while stalled), plays the memory side, checks everything.
    task automatic run_op(input logic [1:0] it, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] s2, input logic [31:0] pc, input logic [6:0] rob,
                          input logic [31:0] rd, input int rdy_dly, input int rsp_dly, input bit noise);
        bit is_mem = (it == 2'd1) || (it == 2'd2);
        bit st     = (it == 2'd2);
        bit trap   = is_mem && TRAP && ref_misal(st, f3, addr);
        logic [31:0] exp_res;
        int lat = 0, rq = 0, wt = 0, phase = 1, exp_lat;
        if (!is_mem || trap) exp_res = addr;
        else if (st)         exp_res = 32'd0;
        else                 exp_res = ref_load(f3, addr, rd);
        exp_lat = (!is_mem || trap) ? 1 : 3 + rdy_dly + rsp_dly;
        in_valid = 1'b1; in_itype = it; in_funct3 = f3; in_alu_result = addr;
        in_s2 = s2; in_pc = pc; in_rob_id = rob;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        #1;
        chk("stall_idle", {31'd0, stall_out}, {31'd0, is_mem && !trap});
        chk("req_idle", {31'd0, mem_req_valid}, 32'd0);
        if (!is_mem || trap) phase = 3;
        while (lat < 60) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (phase == 3) break;
            if (phase == 1) begin
                mem_req_ready  = (rq >= rdy_dly);
                mem_resp_valid = noise && ($urandom_range(1) == 1);
                mem_rdata      = $urandom;
                #1;
                chk("req_valid", {31'd0, mem_req_valid}, 32'd1);
                chk("stall_req", {31'd0, stall_out}, 32'd1);
                chk("wb_early", {31'd0, wb_valid}, 32'd0);
                if (rq == 0) begin
                    chk("mem_addr", mem_addr, addr - (addr % 4));
                    chk("mem_we", {31'd0, mem_we}, {31'd0, st});
                    if (st) begin
                        chk("wdata", mem_wdata, ref_wdata(f3, s2));
                        chk("wstrb", {28'd0, mem_wstrb}, ref_wstrb(f3, addr));
                    end
                end
                if (mem_req_ready) phase = 2;
                rq++;
            end else begin
                mem_req_ready  = 1'b0;
                mem_resp_valid = (wt >= rsp_dly);
                mem_rdata      = mem_resp_valid ? rd : $urandom;
                #1;
                chk("req_wait", {31'd0, mem_req_valid}, 32'd0);
                chk("stall_wait", {31'd0, stall_out}, {31'd0, !mem_resp_valid});
                if (mem_resp_valid) phase = 3;
                wt++;
            end
        end
        in_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        #1;
        if (phase != 3) chk("timeout", 32'd1, 32'd0);
        chk("latency", lat, exp_lat);
        chk("wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("wb_result", wb_result, exp_res);
        chk("wb_pc", wb_pc, pc);
        chk("wb_rob", {25'd0, wb_rob_id}, {25'd0, rob});
        chk("wb_exc", {31'd0, wb_exception}, {31'd0, trap});
        chk("req_after", {31'd0, mem_req_valid}, 32'd0);
        @(posedge clk); @(negedge clk); #1;
        chk("wb_once", {31'd0, wb_valid}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_exc", {31'd0, wb_exception}, 32'd0);
        chk("rst_req", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_result", wb_result, 32'd0);
        chk("rst_pc", wb_pc, 32'd0);
        chk("rst_rob", {25'd0, wb_rob_id}, 32'd0);
        chk("rst_stall", {31'd0, stall_out}, 32'd0);
        reset = 1'b0;
        @(posedge clk); @(negedge clk);

        // directed cases
        run_op(2'd0, 3'd0, 32'h1234, 32'h0, 32'h40, 7'd5, 32'h0, 0, 0, 0);
        run_op(2'd1, 3'd0, 32'h103, 32'h0, 32'h44, 7'd6, 32'h80FF_FF00, 0, 0, 0);
        run_op(2'd2, 3'd1, 32'h102, 32'hABCD, 32'h48, 7'd7, 32'h0, 0, 0, 0);
        run_op(2'd1, 3'd2, 32'h200, 32'h0, 32'h4C, 7'd8, 32'hDEAD_BEEF, 2, 3, 1);
        run_op(2'd3, 3'd2, 32'h5555, 32'h0, 32'h50, 7'd9, 32'h0, 0, 0, 0);
        run_op(2'd1, 3'd2, 32'h102, 32'h0, 32'h54, 7'd10, 32'h1122_3344, 0, 0, 0);
        run_op(2'd1, 3'd5, 32'h303, 32'h0, 32'h58, 7'd11, 32'h9876_5432, 1, 0, 0);

        // back-to-back ALU ops: no bubble
        in_valid = 1'b1; in_itype = 2'd0; in_alu_result = 32'hAAAA; in_pc = 32'h60; in_rob_id = 7'd20;
        #1; chk("b2b_stall_a", {31'd0, stall_out}, 32'd0);
        @(posedge clk); @(negedge clk);
        in_alu_result = 32'hBBBB; in_pc = 32'h64; in_rob_id = 7'd21;
        #1; chk("b2b_wb_a", wb_result, 32'hAAAA);
        chk("b2b_stall_b", {31'd0, stall_out}, 32'd0);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        #1; chk("b2b_wb_b", wb_result, 32'hBBBB);
        chk("b2b_valid_b", {31'd0, wb_valid}, 32'd1);

        // reset while waiting for the response; the late response must be ignored
        in_valid = 1'b1; in_itype = 2'd1; in_funct3 = 3'd2; in_alu_result = 32'h400;
        in_pc = 32'h70; in_rob_id = 7'd30;
        @(posedge clk); @(negedge clk);
        mem_req_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        mem_req_ready = 1'b0; in_valid = 1'b0; reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        #1;
        chk("rstw_stall", {31'd0, stall_out}, 32'd0);
        chk("rstw_req", {31'd0, mem_req_valid}, 32'd0);
        chk("rstw_wb0", {31'd0, wb_valid}, 32'd0);
        @(posedge clk); @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        chk("rstw_wb1", {31'd0, wb_valid}, 32'd0);
        chk("rstw_req1", {31'd0, mem_req_valid}, 32'd0);
        run_op(2'd1, 3'd4, 32'h401, 32'h0, 32'h74, 7'd31, 32'h0000_F100, 0, 1, 0);

        // randomized traffic
        for (int i = 0; i < 200; i++) begin
            logic [1:0]  it  = 2'($urandom_range(3));
            logic [2:0]  f3  = 3'($urandom_range(7));
            logic [31:0] a   = $urandom;
            logic [31:0] s2  = $urandom;
            logic [31:0] pc  = $urandom;
            logic [6:0]  rob = 7'($urandom_range(127));
            logic [31:0] rd  = $urandom;
            run_op(it, f3, a, s2, pc, rob, rd, int'($urandom_range(3)), int'($urandom_range(3)),
                   $urandom_range(1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
